lcd_timing_gen: RTL



---
 rtl/lcd_timing_pkg.sv | 29 ++
 rtl/lcd_delay_line.sv | 32 +++
 rtl/lcd_timing_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared constants, state encoding and helpers for the LCD timing generator.
package lcd_timing_pkg;

  // Minimum result of 1 keeps degenerate counters at a legal width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

endpackage

// File: rtl/lcd_delay_line.sv
// Fixed-depth shift register for panel-side signals; DEPTH=0 degenerates to a wire.
module lcd_delay_line #(
  parameter int unsigned     WIDTH     = 1,
  parameter int unsigned     DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RESET_VAL;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// DE-mode LCD timing generator: frame-gated h/v counters, undelayed fetch strobe and
// pipeline-aligned DE/HSYNC/VSYNC for the panel.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          HS_POL     = POL_LOW,
  parameter bit          VS_POL     = POL_LOW,
  parameter int unsigned PIPE_DEPTH = 3,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW        = clog2(H_TOTAL),
  localparam int unsigned VW        = clog2(V_TOTAL)
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          enable,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          running,
  output logic [7:0]    frame_cnt,
  output logic          de,
  output logic          hsync,
  output logic          vsync
);

  if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_param
    $error("lcd_timing_gen: H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must all be nonzero");
  end

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [31:0]   h_ext, v_ext;
  logic          hs_raw, vs_raw, hs_lvl, vs_lvl;
  logic [2:0]    panel;

  assign h_ext = 32'(h_q);
  assign v_ext = 32'(v_q);

  // enable is only consulted in IDLE and on the last cycle of a frame.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        h_d = '0;
        v_d = '0;
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (h_ext == H_TOTAL - 1) begin
          h_d = '0;
          if (v_ext == V_TOTAL - 1) begin
            v_d         = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (!enable) state_d = StIdle;
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          h_d = h_q + HW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign running     = (state_q == StRun);
  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign frame_cnt   = frame_cnt_q;
  assign active      = running && (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
  assign line_start  = running && (h_q == '0);
  assign frame_start = line_start && (v_q == '0);

  assign hs_raw = running && (h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw = running && (v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC);
  assign hs_lvl = hs_raw ? HS_POL : ~HS_POL;
  assign vs_lvl = vs_raw ? VS_POL : ~VS_POL;

  // Stages reset to idle levels so a reset never leaves a stale pulse in flight.
  lcd_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DEPTH),
    .RESET_VAL({1'b0, ~HS_POL, ~VS_POL})
  ) u_panel_dly (
    .clk (pixel_clk),
    .rst (rst),
    .din ({active, hs_lvl, vs_lvl}),
    .dout(panel)
  );

  assign de    = panel[2];
  assign hsync = panel[1];
  assign vsync = panel[0];

endmodule
